// File: rtl/noc_link_pipeline_monitor_pkg.sv
// Shared types for the router-to-router link stage: flit record and packet framing states.
package noc_link_pipeline_monitor_pkg;

    localparam int DEFAULT_FLIT_WIDTH = 64;
    localparam int DEFAULT_DEST_WIDTH = 6;

    typedef struct packed {
        logic [DEFAULT_FLIT_WIDTH-1:0] data;
        logic [DEFAULT_DEST_WIDTH-1:0] dest;
        logic                          is_tail;
    } flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } link_state_e;

endpackage

// File: rtl/noc_link_pipeline_monitor_pipe.sv
// Valid-qualified shift pipe: DEPTH register stages, or a plain wire when DEPTH is 0.
module noc_pipe_reg #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign valid_out = valid_in;
            assign data_out  = data_in;
        end else begin : g_regs
            logic             valid_q [DEPTH];
            logic [WIDTH-1:0] data_q  [DEPTH];

            // Payload registers only load alongside a valid beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        valid_q[i] <= 1'b0;
                        data_q[i]  <= '0;
                    end
                end else begin
                    valid_q[0] <= valid_in;
                    if (valid_in) data_q[0] <= data_in;
                    for (int i = 1; i < DEPTH; i++) begin
                        valid_q[i] <= valid_q[i-1];
                        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign valid_out = valid_q[DEPTH-1];
            assign data_out  = data_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/noc_link_pipeline_monitor.sv
// Pipelined router-to-router link with an upstream-side credit, framing and traffic monitor.
module noc_link_pipeline_monitor
    import noc_link_pipeline_monitor_pkg::*;
#(
    parameter int NUM_PIPELINE      = 1,
    parameter int FLIT_WIDTH        = DEFAULT_FLIT_WIDTH,
    parameter int DEST_WIDTH        = DEFAULT_DEST_WIDTH,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int COUNT_WIDTH       = 32,
    localparam int CW               = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic [FLIT_WIDTH-1:0]  data_out,
    output logic [DEST_WIDTH-1:0]  dest_out,
    output logic                   is_tail_out,
    output logic                   send_out,
    input  logic                   credit_in,
    input  logic                   clear_err,
    output logic                   err_credit_underflow,
    output logic                   err_credit_overflow,
    output logic                   err_dest_change,
    output logic [CW-1:0]          credit_count,
    output logic [COUNT_WIDTH-1:0] flit_count,
    output logic [COUNT_WIDTH-1:0] pkt_count,
    output link_state_e            state_dbg
);

    localparam int FW = FLIT_WIDTH + DEST_WIDTH + 1;

    logic [FW-1:0] fwd_data;
    logic          cred_valid;
    logic [0:0]    cred_data;

    noc_pipe_reg #(.WIDTH(FW), .DEPTH(NUM_PIPELINE)) u_fwd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (send_in),
        .data_in   ({data_in, dest_in, is_tail_in}),
        .valid_out (send_out),
        .data_out  (fwd_data)
    );

    assign {data_out, dest_out, is_tail_out} = fwd_data;

    noc_pipe_reg #(.WIDTH(1), .DEPTH(NUM_PIPELINE)) u_credit_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (credit_in),
        .data_in   (1'b1),
        .valid_out (cred_valid),
        .data_out  (cred_data)
    );

    assign credit_out = cred_valid & cred_data[0];

    // Credit arithmetic is one bit wider so the overflow case is visible before saturation.
    logic [CW:0]   credit_sum;
    logic [CW:0]   credit_next_w;
    logic [CW-1:0] credit_next;
    logic          underflow_hit;
    logic          overflow_hit;

    always_comb begin
        credit_sum    = {1'b0, credit_count} + {{CW{1'b0}}, credit_out};
        underflow_hit = send_in && (credit_sum == '0);
        credit_next_w = credit_sum;
        if (send_in && !underflow_hit) credit_next_w = credit_sum - (CW+1)'(1);
        overflow_hit  = credit_next_w > (CW+1)'(FLIT_BUFFER_DEPTH);
        credit_next   = overflow_hit ? CW'(FLIT_BUFFER_DEPTH) : credit_next_w[CW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_count         <= CW'(FLIT_BUFFER_DEPTH);
            err_credit_underflow <= 1'b0;
            err_credit_overflow  <= 1'b0;
        end else begin
            credit_count <= credit_next;
            if (underflow_hit)  err_credit_underflow <= 1'b1;
            else if (clear_err) err_credit_underflow <= 1'b0;
            if (overflow_hit)   err_credit_overflow  <= 1'b1;
            else if (clear_err) err_credit_overflow  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flit_count <= '0;
        end else if (send_in) begin
            flit_count <= flit_count + COUNT_WIDTH'(1);
        end
    end

    link_state_e           state;
    logic [DEST_WIDTH-1:0] head_dest;
    logic                  dest_mismatch;

    assign dest_mismatch = send_in && (state == BODY) && (dest_in != head_dest);
    assign state_dbg     = state;

    // Packet framing: the FSM and the counter/flag it owns only move on a sent flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            head_dest       <= '0;
            pkt_count       <= '0;
            err_dest_change <= 1'b0;
        end else begin
            if (dest_mismatch)  err_dest_change <= 1'b1;
            else if (clear_err) err_dest_change <= 1'b0;
            if (send_in) begin
                if (is_tail_in) pkt_count <= pkt_count + COUNT_WIDTH'(1);
                case (state)
                    IDLE: begin
                        head_dest <= dest_in;
                        if (!is_tail_in) state <= BODY;
                    end
                    BODY: begin
                        if (is_tail_in) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noc_link_pipeline_monitor.sv
// Directed bench for the link stage: latency, credit accounting, framing errors and reset.
module tb_noc_link_pipeline_monitor;
    import noc_link_pipeline_monitor_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data_in = '0;
    logic [5:0]  dest_in = '0;
    logic        is_tail_in = 1'b0;
    logic        send_in = 1'b0;
    logic        credit_in = 1'b0;
    logic        clear_err = 1'b0;
    logic        credit_out, is_tail_out, send_out;
    logic [63:0] data_out;
    logic [5:0]  dest_out;
    logic        err_u, err_o, err_d;
    logic [1:0]  credit_count;
    logic [31:0] flit_count, pkt_count;
    link_state_e state_dbg;

    int tests = 0;
    int fails = 0;

    noc_link_pipeline_monitor #(
        .NUM_PIPELINE(2), .FLIT_WIDTH(64), .DEST_WIDTH(6),
        .FLIT_BUFFER_DEPTH(2), .COUNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .data_in(data_in), .dest_in(dest_in), .is_tail_in(is_tail_in), .send_in(send_in),
        .credit_out(credit_out),
        .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out), .send_out(send_out),
        .credit_in(credit_in), .clear_err(clear_err),
        .err_credit_underflow(err_u), .err_credit_overflow(err_o), .err_dest_change(err_d),
        .credit_count(credit_count), .flit_count(flit_count), .pkt_count(pkt_count),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        send;
        logic        tail;
        logic [5:0]  dest;
        logic        credit;
        logic        clear;
        logic [1:0]  exp_cc;
        logic [31:0] exp_flits;
        logic [31:0] exp_pkts;
        logic        exp_u;
        logic        exp_o;
        logic        exp_d;
        logic        exp_body;
    } vec_t;

    vec_t vecs [24];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        flit_t f;

        // Reset state
        step();
        step();
        check("rst send_out", send_out, 0);
        check("rst credit_out", credit_out, 0);
        check("rst data_out", data_out, 0);
        check("rst credit_count", credit_count, 2);
        check("rst flit_count", flit_count, 0);
        check("rst pkt_count", pkt_count, 0);
        check("rst errors", {err_u, err_o, err_d}, 0);
        check("rst state", state_dbg, IDLE);
        rst_n = 1'b1;

        // Two-cycle forward and return latency
        f = '{data: 64'hDEAD_BEEF_1234_5678, dest: 6'h2A, is_tail: 1'b1};
        {data_in, dest_in, is_tail_in} = f;
        send_in = 1'b1;
        step();
        send_in = 1'b0;
        check("lat send_out c1", send_out, 0);
        check("lat count after send", credit_count, 1);
        step();
        check("lat send_out c2", send_out, 1);
        check("lat flit c2", {data_out, dest_out, is_tail_out}, f);
        step();
        check("lat send_out c3", send_out, 0);
        credit_in = 1'b1;
        step();
        credit_in = 1'b0;
        check("lat credit_out c1", credit_out, 0);
        step();
        check("lat credit_out c2", credit_out, 1);
        step();
        check("lat credit_out c3", credit_out, 0);
        check("lat count restored", credit_count, 2);

        rst_n = 1'b0;
        #1;
        check("rerst flit_count", flit_count, 0);
        step();
        rst_n = 1'b1;

        // send, tail, dest, credit, clear | cc, flits, pkts, u, o, d, body
        vecs[0]  = '{1'b1, 1'b1, 6'h01, 1'b0, 1'b0, 2'd1, 32'd1,  32'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 6'h01, 1'b0, 1'b0, 2'd0, 32'd2,  32'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 6'h01, 1'b0, 1'b0, 2'd0, 32'd3,  32'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b1, 2'd0, 32'd3,  32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 32'd3,  32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 2'd1, 32'd3,  32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 2'd2, 32'd3,  32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 2'd2, 32'd3,  32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 2'd2, 32'd3,  32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 2'd2, 32'd3,  32'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 2'd2, 32'd3,  32'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 6'h02, 1'b0, 1'b0, 2'd1, 32'd4,  32'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 6'h02, 1'b1, 1'b0, 2'd0, 32'd5,  32'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 2'd0, 32'd5,  32'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 6'h02, 1'b0, 1'b0, 2'd0, 32'd6,  32'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 32'd6,  32'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 2'd0, 32'd6,  32'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 2'd1, 32'd6,  32'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 2'd2, 32'd6,  32'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b0, 6'h05, 1'b1, 1'b0, 2'd1, 32'd7,  32'd6, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 6'h05, 1'b1, 1'b0, 2'd0, 32'd8,  32'd6, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 6'h09, 1'b0, 1'b0, 2'd0, 32'd9,  32'd6, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[22] = '{1'b1, 1'b1, 6'h05, 1'b0, 1'b0, 2'd0, 32'd10, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 2'd0, 32'd10, 32'd7, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 24; i++) begin
            send_in    = vecs[i].send;
            is_tail_in = vecs[i].tail;
            dest_in    = vecs[i].dest;
            data_in    = {32'hC0DE_0000, 32'(i)};
            credit_in  = vecs[i].credit;
            clear_err  = vecs[i].clear;
            step();
            check($sformatf("vec%0d credit_count", i), credit_count, vecs[i].exp_cc);
            check($sformatf("vec%0d flit_count", i), flit_count, vecs[i].exp_flits);
            check($sformatf("vec%0d pkt_count", i), pkt_count, vecs[i].exp_pkts);
            check($sformatf("vec%0d err_underflow", i), err_u, vecs[i].exp_u);
            check($sformatf("vec%0d err_overflow", i), err_o, vecs[i].exp_o);
            check($sformatf("vec%0d err_dest", i), err_d, vecs[i].exp_d);
            check($sformatf("vec%0d state", i), state_dbg, vecs[i].exp_body ? BODY : IDLE);
        end
        send_in   = 1'b0;
        clear_err = 1'b0;

        // Reset in the middle of a packet with flits still in the pipe
        credit_in = 1'b1;
        step();
        step();
        credit_in = 1'b0;
        step();
        step();
        check("mid count refilled", credit_count, 2);
        send_in = 1'b1; is_tail_in = 1'b0; dest_in = 6'h03;
        step();
        step();
        send_in = 1'b0;
        check("mid head in flight", send_out, 1);
        rst_n = 1'b0;
        #1;
        check("mid rst send_out", send_out, 0);
        check("mid rst credit_count", credit_count, 2);
        check("mid rst state", state_dbg, IDLE);
        check("mid rst flit_count", flit_count, 0);
        step();
        rst_n = 1'b1;
        send_in = 1'b1; is_tail_in = 1'b0; dest_in = 6'h07;
        step();
        is_tail_in = 1'b1;
        step();
        send_in = 1'b0; is_tail_in = 1'b0;
        check("post rst err_dest", err_d, 0);
        check("post rst err_underflow", err_u, 0);
        check("post rst pkt_count", pkt_count, 1);
        check("post rst flit_count", flit_count, 2);
        check("post rst state", state_dbg, IDLE);
        check("post rst credit_count", credit_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
